// File: rtl/fibo_stream_checker.sv
// Fibonacci stream checker: verifies each accepted term against the sum of the previous two,
// re-seeds after a mismatch, and buffers all accepted terms in a first-word-fall-through FIFO.
module fibo_stream_checker #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             locked,
    output logic             seq_err,
    output logic [CNTW-1:0]  err_count,
    output logic [CNTW-1:0]  drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {SEED0, SEED1, LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt, w_exp;
    logic             w_mismatch;
    logic             r_locked, r_seq_err;
    logic [CNTW-1:0]  r_err_cnt, r_drop_cnt;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             w_full, w_pop, w_push, w_drop;

    // Sum truncates to WIDTH bits, which is exactly the mod 2^WIDTH the generator produces.
    assign w_exp = r_p1 + r_p2;

    always_comb begin
        w_state_nxt = r_state;
        w_p1_nxt    = r_p1;
        w_p2_nxt    = r_p2;
        w_mismatch  = 1'b0;
        if (in_valid) begin
            case (r_state)
                SEED0: begin
                    w_p2_nxt    = in_data;
                    w_state_nxt = SEED1;
                end
                SEED1: begin
                    w_p1_nxt    = in_data;
                    w_state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (in_data == w_exp) begin
                        w_p2_nxt = r_p1;
                        w_p1_nxt = in_data;
                    end else begin
                        // Offending term seeds the new sequence.
                        w_mismatch  = 1'b1;
                        w_p2_nxt    = in_data;
                        w_state_nxt = SEED1;
                    end
                end
                default: w_state_nxt = SEED0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= SEED0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_locked  <= 1'b0;
            r_seq_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_p1      <= w_p1_nxt;
            r_p2      <= w_p2_nxt;
            r_locked  <= (w_state_nxt == LOCKED);
            r_seq_err <= w_mismatch;
            if (w_mismatch && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = in_valid & (~w_full | w_pop);
    assign w_drop = in_valid & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push)
            r_mem[r_wptr] <= in_data;
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rptr];
    assign locked     = r_locked;
    assign seq_err    = r_seq_err;
    assign err_count  = r_err_cnt;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Randomised and directed bench for fibo_stream_checker against a queue-based behavioural model.
module tb_fibo_stream_checker;
    localparam int WIDTH = 5;
    localparam int DEPTH = 8;
    localparam int CNTW  = 8;
    localparam int MODV  = 1 << WIDTH;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             locked;
    logic             seq_err;
    logic [CNTW-1:0]  err_count;
    logic [CNTW-1:0]  drop_count;

    fibo_stream_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .locked(locked), .seq_err(seq_err),
        .err_count(err_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: how many terms of the current run are known (0,1,2+), the last two of them,
    // the FIFO as a queue, and the debug counters.
    int mq[$];
    int mseen, molder, mnewer, merr, mdrop, mserr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_next();
        return (molder + mnewer) % MODV;
    endfunction

    task automatic model_edge(input logic r, input logic v, input int d, input logic rdy);
        if (!r) begin
            mq.delete();
            mseen = 0; molder = 0; mnewer = 0; merr = 0; mdrop = 0; mserr = 0;
            return;
        end
        mserr = 0;
        if (v) begin
            if (mseen == 0) begin
                molder = d; mseen = 1;
            end else if (mseen == 1) begin
                mnewer = d; mseen = 2;
            end else if (d == model_next()) begin
                molder = mnewer; mnewer = d;
            end else begin
                mserr = 1;
                if (merr < CMAX) merr++;
                molder = d; mseen = 1;
            end
        end
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (v) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else if (mdrop < CMAX) mdrop++;
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, compare away from the edge.
    task automatic step(input logic r, input logic v, input int d, input logic rdy);
        rst = r; in_valid = v; in_data = WIDTH'(d); out_ready = rdy;
        @(posedge clk);
        model_edge(r, v, d, rdy);
        @(negedge clk);
        chk("out_valid",  32'(out_valid),  32'(mq.size() > 0));
        if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("locked",     32'(locked),     32'(mseen == 2));
        chk("seq_err",    32'(seq_err),    32'(mserr));
        chk("err_count",  32'(err_count),  32'(merr));
        chk("drop_count", 32'(drop_count), 32'(mdrop));
    endtask

    task automatic feed(input int vals[$], input logic rdy);
        foreach (vals[i]) step(1'b1, 1'b1, vals[i], rdy);
    endtask

    initial begin
        int d;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 0, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_locked",    32'(locked), 0);

        // Nominal lock; locked rises after the second term
        step(1'b1, 1'b1, 0, 1'b1);
        chk("nom_unlocked_1", 32'(locked), 0);
        chk("nom_head0",      32'(out_data), 0);
        step(1'b1, 1'b1, 1, 1'b1);
        chk("nom_locked_2",   32'(locked), 1);
        chk("nom_head1",      32'(out_data), 1);
        feed('{1, 2, 3, 5, 8}, 1'b1);
        chk("nom_last",       32'(out_data), 8);
        chk("nom_err0",       32'(err_count), 0);
        step(1'b1, 1'b0, 0, 1'b1);
        chk("nom_drained",    32'(out_valid), 0);

        // Wrap-around: 21+13 = 34 -> 2
        step(1'b0, 1'b0, 0, 1'b1);
        feed('{8, 13, 21, 2, 23, 25}, 1'b1);
        chk("wrap_head",  32'(out_data), 25);
        chk("wrap_err0",  32'(err_count), 0);
        chk("wrap_lock",  32'(locked), 1);

        // Mismatch and resync: 4 breaks the run, 6 re-locks, 10 matches
        step(1'b0, 1'b0, 0, 1'b1);
        feed('{0, 1, 1, 2}, 1'b1);
        step(1'b1, 1'b1, 4, 1'b1);
        chk("mm_pulse",    32'(seq_err), 1);
        chk("mm_unlock",   32'(locked), 0);
        step(1'b1, 1'b1, 6, 1'b1);
        chk("mm_pulse_end", 32'(seq_err), 0);
        chk("mm_relock",   32'(locked), 1);
        step(1'b1, 1'b1, 10, 1'b1);
        chk("mm_err1",     32'(err_count), 1);
        chk("mm_noerr",    32'(seq_err), 0);

        // Overflow with sink stalled, then full push/pop, then drain
        step(1'b0, 1'b0, 0, 1'b0);
        feed('{0, 1, 1, 2, 3, 5, 8, 13, 21, 2}, 1'b0);
        chk("ovf_drop2",  32'(drop_count), 2);
        chk("ovf_head",   32'(out_data), 0);
        feed('{23, 25, 16}, 1'b1);
        chk("pp_drop2",   32'(drop_count), 2);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, 0, 1'b1);
        chk("ovf_empty",  32'(out_valid), 0);

        // Reset mid-operation, then gapped seeding
        step(1'b0, 1'b0, 0, 1'b1);
        feed('{0, 1, 1, 2, 4}, 1'b0);
        chk("mid_err1",   32'(err_count), 1);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("mid_rst_v",  32'(out_valid), 0);
        chk("mid_rst_e",  32'(err_count), 0);
        step(1'b1, 1'b1, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 1, 1'b1);
        chk("gap_locked", 32'(locked), 1);
        step(1'b1, 1'b0, 0, 1'b1);
        step(1'b1, 1'b1, 1, 1'b1);
        chk("gap_match",  32'(seq_err), 0);

        // Random traffic: mostly series-correct terms, some corruption, random stalls and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 80 && mseen == 2) d = model_next();
            else d = int'($urandom_range(MODV - 1));
            step(($urandom_range(199) != 0), ($urandom_range(3) != 0), d,
                 ($urandom_range(2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
